// File: rtl/debug_dump_sequencer_pkg.sv
// Shared definitions for the debug dump sequencer:
//   - FSM state encoding
//   - database field selector codes
//   - helper that derives the number of bytes in a captured word
package debug_dump_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_LATCH   = 3'd2,
      ST_SEND    = 3'd3,
      ST_WAIT_TX = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   // database field selector codes
   localparam int CAMPO_PC          = 1;
   localparam int CAMPO_ADDER_PC    = 2;
   localparam int CAMPO_INSTRUCCION = 3;
   localparam int CAMPO_CICLOS      = 4;
   localparam int CAMPO_BRANCH      = 5;
   localparam int CAMPO_DATA_A      = 6;
   localparam int CAMPO_DATA_B      = 7;
   localparam int CAMPO_EXT_SIGNO   = 8;
   localparam int CAMPO_RS_RT_RD    = 9;
   localparam int CAMPO_CONTROL_EX  = 10;
   localparam int CAMPO_CONTROL_WB  = 11;

   localparam int LONGITUD_DATO_DEF = 32;

   function automatic int bytes_por_dato(input int longitud);
      return longitud / 8;
   endfunction

   localparam int BYTES_POR_DATO = bytes_por_dato(LONGITUD_DATO_DEF);

endpackage

// File: rtl/debug_dump_sequencer_word_serializer.sv
// word_serializer: holds one captured database word and presents it to the
// UART transmitter MSB-first, one byte at a time.
//   i_clock, i_soft_reset : clock / async active-low reset
//   i_load                : capture i_dato, restart byte count
//   i_shift               : current byte finished, advance to the next one
//   i_dato                : word from database
//   o_tx_data             : byte currently presented to the transmitter
//   o_ultimo_byte         : the presented byte is the last of the word
module word_serializer
   import debug_dump_sequencer_pkg::*;
#(
   parameter int LONGITUD_DATO     = 32,
   parameter int CANT_BITS_DATO_TX = 8
) (
   input  logic                         i_clock,
   input  logic                         i_soft_reset,
   input  logic                         i_load,
   input  logic                         i_shift,
   input  logic [LONGITUD_DATO-1:0]     i_dato,
   output logic [CANT_BITS_DATO_TX-1:0] o_tx_data,
   output logic                         o_ultimo_byte
);

   localparam int BYTES = bytes_por_dato(LONGITUD_DATO);
   localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [LONGITUD_DATO-1:0] r_shift;
   logic [CW-1:0]            r_cnt;

   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shift <= i_dato;
         r_cnt   <= '0;
      end else if (i_shift) begin
         r_shift <= r_shift << CANT_BITS_DATO_TX;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // The top byte of the register is the byte on the wire; it stays put
   // while the transmitter works because shifting only happens on done.
   assign o_tx_data     = r_shift[LONGITUD_DATO-1 -: CANT_BITS_DATO_TX];
   assign o_ultimo_byte = (r_cnt == CW'(BYTES - 1));

endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: walks the database field selectors, captures each
// word and streams it byte by byte to uart_tx.
//   i_clock      : system clock
//   i_soft_reset : async active-low reset
//   i_start      : pulse, begin a dump
//   i_dato       : selected database word
//   i_tx_done    : pulse from uart_tx, byte finished
//   o_control    : database field selector
//   o_tx_data    : byte to transmit
//   o_tx_start   : pulse, transmit o_tx_data
//   o_busy       : dump in progress
//   o_done       : pulse, dump complete
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for i_start, selector parked at 0
// SELECT   | selector driven, waiting for database latency
// LATCH    | capture i_dato into the serializer
// SEND     | o_tx_start asserted for the current byte
// WAIT_TX  | waiting for i_tx_done
// DONE     | o_done pulse, back to IDLE
module debug_dump_sequencer
   import debug_dump_sequencer_pkg::*;
#(
   parameter int LONGITUD_DATO     = 32,
   parameter int CANT_BITS_CONTROL = 4,
   parameter int PRIMER_CAMPO      = CAMPO_PC,
   parameter int ULTIMO_CAMPO      = CAMPO_CONTROL_WB,
   parameter int LATENCIA_DATABASE = 1,
   parameter int CANT_BITS_DATO_TX = 8
) (
   input  logic                         i_clock,
   input  logic                         i_soft_reset,
   input  logic                         i_start,
   input  logic [LONGITUD_DATO-1:0]     i_dato,
   input  logic                         i_tx_done,
   output logic [CANT_BITS_CONTROL-1:0] o_control,
   output logic [CANT_BITS_DATO_TX-1:0] o_tx_data,
   output logic                         o_tx_start,
   output logic                         o_busy,
   output logic                         o_done
);

   localparam logic [CANT_BITS_CONTROL-1:0] W_PRIMER = CANT_BITS_CONTROL'(PRIMER_CAMPO);
   localparam logic [CANT_BITS_CONTROL-1:0] W_ULTIMO = CANT_BITS_CONTROL'(ULTIMO_CAMPO);
   localparam logic [2:0]                   W_LAT_TC = 3'(LATENCIA_DATABASE - 1);

   state_t                       r_state;
   logic [CANT_BITS_CONTROL-1:0] r_field;
   logic [2:0]                   r_lat;

   logic w_load;
   logic w_shift;
   logic w_ultimo_byte;

   assign w_load  = (r_state == ST_LATCH);
   assign w_shift = (r_state == ST_WAIT_TX) && i_tx_done;

   word_serializer #(
      .LONGITUD_DATO     (LONGITUD_DATO),
      .CANT_BITS_DATO_TX (CANT_BITS_DATO_TX)
   ) u_word_serializer (
      .i_clock       (i_clock),
      .i_soft_reset  (i_soft_reset),
      .i_load        (w_load),
      .i_shift       (w_shift),
      .i_dato        (i_dato),
      .o_tx_data     (o_tx_data),
      .o_ultimo_byte (w_ultimo_byte)
   );

   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         r_state    <= ST_IDLE;
         r_field    <= '0;
         r_lat      <= '0;
         o_control  <= '0;
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         o_done     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               o_control <= '0;
               if (i_start) begin
                  r_field   <= W_PRIMER;
                  o_control <= W_PRIMER;
                  r_lat     <= W_LAT_TC;
                  o_busy    <= 1'b1;
                  r_state   <= ST_SELECT;
               end
            end
            // down-counter loaded with latency-1 so SELECT lasts exactly
            // LATENCIA_DATABASE cycles
            ST_SELECT: begin
               if (r_lat == 3'd0) r_state <= ST_LATCH;
               else               r_lat   <= r_lat - 3'd1;
            end
            ST_LATCH: begin
               o_tx_start <= 1'b1;
               r_state    <= ST_SEND;
            end
            ST_SEND: begin
               r_state <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (i_tx_done) begin
                  if (!w_ultimo_byte) begin
                     o_tx_start <= 1'b1;
                     r_state    <= ST_SEND;
                  end else if (r_field == W_ULTIMO) begin
                     o_done    <= 1'b1;
                     o_control <= '0;
                     r_state   <= ST_DONE;
                  end else begin
                     r_field   <= r_field + 1'b1;
                     o_control <= r_field + 1'b1;
                     r_lat     <= W_LAT_TC;
                     r_state   <= ST_SELECT;
                  end
               end
            end
            ST_DONE: begin
               o_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
module tb_debug_dump_sequencer;
   localparam int N = 3;   // 0: defaults, 1: latency 3, 2: single field 7

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start   [N];
   logic        tx_done [N];
   logic [31:0] dato    [N];
   logic [3:0]  ctl     [N];
   logic [7:0]  txd     [N];
   logic        txs     [N];
   logic        busy    [N];
   logic        done    [N];

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural database: word per selector, valid once the selector has
   // been stable for the configured latency, random garbage before that
   logic [31:0] word_tab [16];
   logic [3:0]  mdl_last [N];
   int          mdl_age  [N];
   logic [31:0] garb     [N];

   function automatic int lat_of(input int i);  return (i == 1) ? 3 : 1;  endfunction
   function automatic int prim_of(input int i); return (i == 2) ? 7 : 1;  endfunction
   function automatic int ult_of(input int i);  return (i == 2) ? 7 : 11; endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      debug_dump_sequencer #(
         .LONGITUD_DATO     (32),
         .CANT_BITS_CONTROL (4),
         .PRIMER_CAMPO      ((g == 2) ? 7 : 1),
         .ULTIMO_CAMPO      ((g == 2) ? 7 : 11),
         .LATENCIA_DATABASE ((g == 1) ? 3 : 1),
         .CANT_BITS_DATO_TX (8)
      ) u_dut (
         .i_clock      (clk),
         .i_soft_reset (rst_n),
         .i_start      (start[g]),
         .i_dato       (dato[g]),
         .i_tx_done    (tx_done[g]),
         .o_control    (ctl[g]),
         .o_tx_data    (txd[g]),
         .o_tx_start   (txs[g]),
         .o_busy       (busy[g]),
         .o_done       (done[g])
      );
      assign dato[g] = (mdl_age[g] >= lat_of(g)) ? word_tab[mdl_last[g]] : garb[g];
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         garb[i] <= $urandom;
         if (ctl[i] != mdl_last[i]) begin
            mdl_last[i] <= ctl[i];
            mdl_age[i]  <= 1;
         end else if (mdl_age[i] < 15) begin
            mdl_age[i] <= mdl_age[i] + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pattern_words();
      for (int f = 0; f < 16; f++)
         word_tab[f] = {8'(f), 8'(f + 16), 8'(f + 32), 8'(f + 48)};
   endtask

   task automatic chk_idle(input int inst, input string tag);
      chk($sformatf("%s ctl[%0d]", tag, inst),  {28'd0, ctl[inst]}, 32'd0);
      chk($sformatf("%s txd[%0d]", tag, inst),  {24'd0, txd[inst]}, 32'd0);
      chk($sformatf("%s txs[%0d]", tag, inst),  {31'd0, txs[inst]}, 32'd0);
      chk($sformatf("%s busy[%0d]", tag, inst), {31'd0, busy[inst]}, 32'd0);
      chk($sformatf("%s done[%0d]", tag, inst), {31'd0, done[inst]}, 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin start[i] = 1'b0; tx_done[i] = 1'b0; end
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One dump on instance inst. Expected byte stream is built from the word
   // table: every field in range, each word MSB byte first.
   task automatic run_dump(input int inst, input bit rnd, input bit inject,
                           input int abort_at, input string tag);
      logic [7:0] exp_q[$];
      int nb = 0, nd = 0, cd = 0, cyc = 0;
      bit fin = 0, aborted = 0, start5 = 0;
      for (int f = prim_of(inst); f <= ult_of(inst); f++)
         for (int b = 0; b < 4; b++)
            exp_q.push_back(8'(word_tab[f] >> (24 - 8 * b)));
      @(negedge clk);
      start[inst] = 1'b1;
      @(negedge clk);
      start[inst] = 1'b0;
      while (!fin && cyc < 4000) begin
         tx_done[inst] = 1'b0;
         start[inst]   = 1'b0;
         if (!done[inst])
            chk($sformatf("%s busy", tag), {31'd0, busy[inst]}, 32'd1);
         if (txs[inst]) begin
            if (nb < exp_q.size()) begin
               chk($sformatf("%s byte%0d", tag, nb), {24'd0, txd[inst]}, {24'd0, exp_q[nb]});
               chk($sformatf("%s ctl@byte%0d", tag, nb), {28'd0, ctl[inst]},
                   32'(prim_of(inst) + nb / 4));
            end
            nb++;
            cd = rnd ? $urandom_range(1, 6) : 3;
            if (abort_at >= 0 && nb == abort_at) begin
               aborted = 1;
               fin = 1;
            end
         end
         if (done[inst]) begin
            nd++;
            fin = 1;
            chk($sformatf("%s ctl@done", tag), {28'd0, ctl[inst]}, 32'd0);
         end
         if (!fin) begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) tx_done[inst] = 1'b1;
            end else if (inject && $urandom_range(0, 5) == 0) begin
               tx_done[inst] = 1'b1;
            end
            if (inject && busy[inst] && !done[inst] &&
                ((nb == 5 && !start5) || $urandom_range(0, 9) == 0)) begin
               start[inst] = 1'b1;
               if (nb == 5) start5 = 1;
            end
            @(negedge clk);
            cyc++;
         end
      end
      tx_done[inst] = 1'b0;
      start[inst]   = 1'b0;
      if (!aborted) begin
         chk($sformatf("%s timeout", tag), {31'd0, fin}, 32'd1);
         chk($sformatf("%s nbytes", tag), 32'(nb), 32'(exp_q.size()));
         chk($sformatf("%s ndone", tag), 32'(nd), 32'd1);
         @(negedge clk);
         chk($sformatf("%s busy after", tag), {31'd0, busy[inst]}, 32'd0);
         chk($sformatf("%s done after", tag), {31'd0, done[inst]}, 32'd0);
         chk($sformatf("%s ctl after", tag), {28'd0, ctl[inst]}, 32'd0);
         nb = 0;
         repeat (6) begin
            @(negedge clk);
            if (txs[inst]) nb++;
         end
         chk($sformatf("%s quiet after", tag), 32'(nb), 32'd0);
      end
   endtask

   typedef struct {
      logic       s;
      logic       d;
      logic       busy;
      logic [3:0] ctl;
      logic       txs;
      logic [7:0] txd;
      logic       done;
   } vec_t;

   vec_t vecs [15];

   initial begin
      int cnt;
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         start[i] = 1'b0; tx_done[i] = 1'b0;
         mdl_last[i] = '0; mdl_age[i] = 0; garb[i] = '0;
      end
      pattern_words();

      // reset state
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) chk_idle(i, "reset");
      rst_n = 1'b1;

      //            s  d  busy ctl  txs txd    done
      vecs[0]  = '{0, 0, 0, 4'd0, 0, 8'h00, 0};
      vecs[1]  = '{1, 0, 1, 4'd1, 0, 8'h00, 0};
      vecs[2]  = '{0, 1, 1, 4'd1, 0, 8'h00, 0};
      vecs[3]  = '{0, 0, 1, 4'd1, 1, 8'h01, 0};
      vecs[4]  = '{1, 1, 1, 4'd1, 0, 8'h01, 0};
      vecs[5]  = '{0, 0, 1, 4'd1, 0, 8'h01, 0};
      vecs[6]  = '{0, 1, 1, 4'd1, 1, 8'h11, 0};
      vecs[7]  = '{0, 0, 1, 4'd1, 0, 8'h11, 0};
      vecs[8]  = '{0, 1, 1, 4'd1, 1, 8'h21, 0};
      vecs[9]  = '{0, 0, 1, 4'd1, 0, 8'h21, 0};
      vecs[10] = '{0, 1, 1, 4'd1, 1, 8'h31, 0};
      vecs[11] = '{0, 0, 1, 4'd1, 0, 8'h31, 0};
      vecs[12] = '{0, 1, 1, 4'd2, 0, 8'h00, 0};
      vecs[13] = '{0, 0, 1, 4'd2, 0, 8'h00, 0};
      vecs[14] = '{0, 0, 1, 4'd2, 1, 8'h02, 0};
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         start[0]   = vecs[i].s;
         tx_done[0] = vecs[i].d;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d busy", i), {31'd0, busy[0]}, {31'd0, vecs[i].busy});
         chk($sformatf("vec%0d ctl", i),  {28'd0, ctl[0]},  {28'd0, vecs[i].ctl});
         chk($sformatf("vec%0d txs", i),  {31'd0, txs[0]},  {31'd0, vecs[i].txs});
         chk($sformatf("vec%0d txd", i),  {24'd0, txd[0]},  {24'd0, vecs[i].txd});
         chk($sformatf("vec%0d done", i), {31'd0, done[0]}, {31'd0, vecs[i].done});
      end
      do_reset(1);

      run_dump(0, 0, 0, -1, "full");
      run_dump(0, 0, 1, -1, "ignored");

      // mid-dump reset
      run_dump(0, 0, 0, 10, "abort");
      #1 rst_n = 1'b0;
      #1 chk_idle(0, "midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tx_done[0] = 1'b1;
      @(negedge clk);
      tx_done[0] = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (txs[0] || busy[0]) cnt++;
      end
      chk("late tx_done ignored", 32'(cnt), 32'd0);
      run_dump(0, 0, 0, -1, "restart");

      run_dump(1, 0, 0, -1, "lat3");

      word_tab[7] = 32'hDEADBEEF;
      run_dump(2, 0, 0, -1, "single");

      for (int it = 0; it < 6; it++) begin
         for (int f = 0; f < 16; f++) word_tab[f] = $urandom;
         run_dump(it % N, 1, 1, -1, $sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
